// File: rtl/serial_rx_24_if.sv
// ---------------------------------------------------------------------------
// serial_rx_24_if -- bundle of the serial receiver's handshake and status lines.
//
// Signals
//   Start       frame-start strobe (producer -> receiver)
//   Bit_In      serial data bit     (producer -> receiver)
//   Bit_Valid   qualifies Bit_In    (producer -> receiver)
//   Data_Ready  consumer acceptance (consumer -> receiver)
//   Data_Out    assembled word      (receiver -> consumer)
//   Data_Valid  Data_Out holds an unconsumed word
//   Busy        frame in progress
//   Overrun     sticky: a completed word was dropped
//   Parity_Err  one-cycle pulse on a parity mismatch
//
// Modports
//   master  the environment side (bit producer and word consumer)
//   slave   the receiver itself
// ---------------------------------------------------------------------------
interface serial_rx_24_if #(
    parameter int unsigned WIDTH = 24
);
    logic             Start;
    logic             Bit_In;
    logic             Bit_Valid;
    logic             Data_Ready;
    logic [WIDTH-1:0] Data_Out;
    logic             Data_Valid;
    logic             Busy;
    logic             Overrun;
    logic             Parity_Err;

    modport master (
        output Start, Bit_In, Bit_Valid, Data_Ready,
        input  Data_Out, Data_Valid, Busy, Overrun, Parity_Err
    );

    modport slave (
        input  Start, Bit_In, Bit_Valid, Data_Ready,
        output Data_Out, Data_Valid, Busy, Overrun, Parity_Err
    );
endinterface

// File: rtl/serial_rx_24.sv
// ---------------------------------------------------------------------------
// serial_rx_24 -- LSB-first serial-to-parallel receiver with a one-word
// output holding register and valid/ready handoff.
//
// A Start strobe opens a frame; every Bit_Valid cycle shifts Bit_In into the
// MSB of the shift register, so after WIDTH bits the first bit sits at bit 0.
// The completed word is copied to Data_Out one edge after its last bit and is
// held until the consumer takes it (Data_Valid & Data_Ready). A word that
// completes while the previous one is still unconsumed is dropped and the
// sticky Overrun flag is set.
//
// Ports
//   Clk     system clock, rising edge
//   Reset   synchronous, active-high; priority over all other inputs
//   bus     serial_rx_24_if.slave (Start, Bit_In, Bit_Valid, Data_Ready in;
//           Data_Out, Data_Valid, Busy, Overrun, Parity_Err out)
//
// Parameters
//   WIDTH   data word width, 2..32
//
// Build option
//   RX_PARITY_EN  when defined, each frame carries one extra even-parity bit
//                 after the data bits (state PAR). A mismatch discards the word
//                 and pulses Parity_Err. Undefined: Parity_Err is tied 0.
// ---------------------------------------------------------------------------
module serial_rx_24 #(
    parameter int unsigned WIDTH = 24
) (
    input logic          Clk,
    input logic          Reset,
    serial_rx_24_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef RX_PARITY_EN
    typedef enum logic [1:0] {StIdle, StRecv, StPar} state_t;
`else
    typedef enum logic [1:0] {StIdle, StRecv} state_t;
`endif

    state_t           state;
    logic [CntW-1:0]  bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             overrun;
`ifdef RX_PARITY_EN
    logic             parity_err;
`endif

    logic [WIDTH-1:0] shift_next;
    logic             last_bit;
    logic             can_load;

    // Word as it stands after consuming the current bit.
    assign shift_next = {bus.Bit_In, shift_reg[WIDTH-1:1]};
    assign last_bit   = (bit_cnt == CntW'(WIDTH - 1));
    // The holding register is free if empty or being emptied this cycle; the
    // latter covers a completion coinciding with a handshake.
    assign can_load   = !data_valid || bus.Data_Ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= StIdle;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
`ifdef RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // Handshake clears valid; a same-cycle load below overrides it.
            if (data_valid && bus.Data_Ready) begin
                data_valid <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (bus.Start) begin
                        state     <= StRecv;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end

                StRecv: begin
                    if (bus.Start) begin
                        // Abort and restart; the bit offered with Start is ignored.
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end else if (bus.Bit_Valid) begin
                        shift_reg <= shift_next;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (last_bit) begin
`ifdef RX_PARITY_EN
                            state <= StPar;
`else
                            state <= StIdle;
                            if (can_load) begin
                                data_out   <= shift_next;
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
`endif
                        end
                    end
                end

`ifdef RX_PARITY_EN
                StPar: begin
                    if (bus.Start) begin
                        state     <= StRecv;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end else if (bus.Bit_Valid) begin
                        state <= StIdle;
                        // Even parity: the parity bit equals the XOR of the data bits.
                        if (bus.Bit_In == ^shift_reg) begin
                            if (can_load) begin
                                data_out   <= shift_reg;
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            parity_err <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.Data_Out   = data_out;
    assign bus.Data_Valid = data_valid;
    assign bus.Busy       = (state != StIdle);
    assign bus.Overrun    = overrun;
`ifdef RX_PARITY_EN
    assign bus.Parity_Err = parity_err;
`else
    assign bus.Parity_Err = 1'b0;
`endif

endmodule

// File: doc/serial_rx_24.md
SERIAL_RX_24 -- requirements
Module: serial_rx_24

Interface
REQ-001 Parameter WIDTH, default 24, sets the data word width in bits; legal range is 2..32.
REQ-002 Port Clk, input, 1 bit, is the system clock; all state changes on its rising edge.
REQ-003 Port Reset, input, 1 bit, is a synchronous, active-high reset.
REQ-004 Port Start, input, 1 bit, is a one-cycle frame-start strobe.
REQ-005 Port Bit_In, input, 1 bit, is the serial data bit.
REQ-006 Port Bit_Valid, input, 1 bit, qualifies Bit_In; one bit is consumed per cycle it is high.
REQ-007 Port Data_Out, output, WIDTH bits, is the assembled word.
REQ-008 Port Data_Valid, output, 1 bit, is high while Data_Out holds an unconsumed word.
REQ-009 Port Data_Ready, input, 1 bit, is the consumer acceptance signal.
REQ-010 Port Busy, output, 1 bit, is high while a frame is in progress.
REQ-011 Port Overrun, output, 1 bit, is a sticky flag: a completed word was dropped.
REQ-012 Port Parity_Err, output, 1 bit, is a one-cycle pulse for a parity mismatch.

Function
REQ-013 The FSM SHALL have states IDLE and RECV, plus PAR when RX_PARITY_EN is defined.
REQ-014 IDLE SHALL ignore Bit_Valid; Start moves the FSM to RECV and clears the bit counter and the shift register.
REQ-015 In RECV, each Bit_Valid cycle SHALL shift right with Bit_In entering the MSB and increment the bit counter.
  - The first bit received therefore ends at bit 0 (LSB-first), matching the LSB-first shift transmitter.
REQ-016 On the WIDTH-th bit, the FSM SHALL complete the frame:
  - without parity: go to IDLE;
  - with parity: go to PAR.
REQ-017 On frame completion, the word SHALL be copied to Data_Out and Data_Valid SHALL be set on the next edge (1-cycle latency from the last bit).
REQ-018 Data_Valid and Data_Out SHALL hold until a cycle with Data_Valid=1 and Data_Ready=1, after which Data_Valid clears.
REQ-019 If a word completes while Data_Valid=1 and Data_Ready=0:
  - the new word SHALL be dropped;
  - Data_Out SHALL be unchanged;
  - Overrun SHALL set.
REQ-020 If a word completes in the same cycle as a handshake (Data_Valid=1, Data_Ready=1), the new word SHALL load and Data_Valid SHALL stay 1; Overrun SHALL NOT set.
REQ-021 Start in RECV or PAR SHALL abort the frame and restart at bit 0; Bit_Valid in the Start cycle SHALL be ignored.
REQ-022 Busy SHALL be 1 exactly when the FSM is in RECV or PAR.
REQ-023 Overrun SHALL clear only on Reset.
REQ-024 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never exceed WIDTH.

Reset
REQ-025 Reset SHALL be synchronous and active-high, with priority over all other inputs.
REQ-026 On Reset, the following SHALL clear, with no other effect:
  - FSM to IDLE;
  - Data_Out=0, Data_Valid=0, Busy=0, Overrun=0, Parity_Err=0;
  - counter and shift register to 0.
REQ-027 Reset mid-frame SHALL discard the partial frame.

Configuration
REQ-028 Macro RX_PARITY_EN, when defined, SHALL add the PAR state:
  - the next Bit_Valid bit is even parity over the WIDTH data bits;
  - on match, the word is delivered per REQ-017..020;
  - on mismatch, the word is discarded and Parity_Err pulses high for one cycle;
  - in both cases, the FSM returns to IDLE.
REQ-029 When RX_PARITY_EN is undefined, PAR SHALL NOT exist, Parity_Err SHALL be tied 0, and the frame is exactly WIDTH bits.

Verification
REQ-030 Start, then 24 bits of 24'hA5C3F0 LSB-first with Bit_Valid=1 every cycle, Data_Ready=1 -> Data_Out=24'hA5C3F0 and Data_Valid=1 one cycle after the last bit.
REQ-031 Same word with Bit_Valid toggling 1,0,1,0 -> identical Data_Out; Busy=1 for 47 cycles.
REQ-032 Two frames (24'h000001, then 24'hFFFFFF) with Data_Ready=0 -> Data_Out=24'h000001 and Overrun=1 after the second frame.
REQ-033 Start, 10 bits, Start again, then 24 bits of 24'h123456 -> Data_Out=24'h123456.
REQ-034 Reset asserted after 12 bits -> all outputs 0, Busy=0; a following full frame is received correctly.
REQ-035 With RX_PARITY_EN, 24'h000003 followed by parity bit 1 -> Parity_Err pulses once, Data_Valid stays 0.
